// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD types, constants and helpers for the decade down-counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    // Out-of-range nibbles (A..F) are clamped to the largest decimal digit.
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down-counter; the counter sits on the slave side.
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  en;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  busy;
    logic                  done;
    logic                  tc;
    logic                  load_err;

    modport master (
        output start, en, load_val,
        input  q, busy, done, tc, load_err
    );

    modport slave (
        input  start, en, load_val,
        output q, busy, done, tc, load_err
    );
endinterface

// File: rtl/bcd_down_counter_digit.sv
// One decade of the down-counter: load has priority, a zero digit wraps to 9 and borrows.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t d,
    output bcd_digit_t q,
    output logic       is_zero,
    output logic       borrow_out
);

    bcd_digit_t r_q;

    assign q          = r_q;
    assign is_zero    = (r_q == BCD_ZERO);
    assign borrow_out = dec & is_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= BCD_ZERO;
        end else if (load) begin
            r_q <= d;
        end else if (dec) begin
            r_q <= is_zero ? BCD_MAX : (r_q - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with terminal-count pulse and optional auto-reload.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    bcd_down_counter_if.slave bus
);

    localparam int W = 4 * DIGITS;

    cnt_state_t     r_state;
    logic [W-1:0]   r_reload;
    logic           r_tc;
    logic           r_loadErr;

    logic [W-1:0]   w_q;
    logic [W-1:0]   w_sanVal;
    logic [W-1:0]   w_loadVal;
    logic [DIGITS-1:0] w_isZero;
    logic [DIGITS-1:0] w_borrow;
    logic [DIGITS-1:0] w_dec;
    logic           w_anyBad;
    logic           w_run;
    logic           w_qZero;
    logic           w_qOne;
    logic           w_step;
    logic           w_reloadNow;
    logic           w_load;
    logic           w_unusedBorrow;

    always_comb begin
        w_anyBad = 1'b0;
        w_sanVal = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sanVal[4*i +: 4] = bcd_sat(bus.load_val[4*i +: 4]);
            if (bus.load_val[4*i +: 4] > BCD_MAX) begin
                w_anyBad = 1'b1;
            end
        end
    end

    assign w_run       = (r_state == RUN);
    assign w_qZero     = &w_isZero;
    assign w_qOne      = (w_q == W'(1));
    assign w_step      = !bus.start && w_run && bus.en && !w_qZero;
    assign w_reloadNow = !bus.start && w_run && bus.en && w_qZero && RELOAD;
    assign w_load      = bus.start || w_reloadNow;
    assign w_loadVal   = bus.start ? w_sanVal : r_reload;

    // The step is blocked at zero, so a borrow never leaves the top digit.
    assign w_unusedBorrow = w_borrow[DIGITS-1];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsb
                assign w_dec[gi] = w_step;
            end else begin : g_upper
                assign w_dec[gi] = w_borrow[gi-1];
            end

            bcd_digit_dn u_digit (
                .clk        (clk),
                .reset      (reset),
                .dec        (w_dec[gi]),
                .load       (w_load),
                .d          (w_loadVal[4*gi +: 4]),
                .q          (w_q[4*gi +: 4]),
                .is_zero    (w_isZero[gi]),
                .borrow_out (w_borrow[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_reload  <= '0;
            r_tc      <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_tc      <= 1'b0;
            r_loadErr <= 1'b0;
            if (bus.start) begin
                r_reload  <= w_sanVal;
                r_loadErr <= w_anyBad;
                if (w_sanVal != '0) begin
                    r_state <= RUN;
                end else begin
                    r_tc    <= 1'b1;
                    r_state <= RELOAD ? RUN : DONE;
                end
            end else if (w_step && w_qOne) begin
                r_tc <= 1'b1;
                if (!RELOAD) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign bus.q        = w_q;
    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.tc       = r_tc;
    assign bus.load_err = r_loadErr;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Drives three counter configurations in lockstep and checks them against an integer model.
module tb_bcd_down_counter;

    typedef struct {
        int value;
        int reloadVal;
        int st;
        bit tc;
        bit err;
    } model_t;

    typedef struct {
        bit         start;
        bit         en;
        logic [11:0] lv;
        logic [7:0] expQ;
        bit         expTc;
        bit         expBusy;
        bit         expDone;
        bit         expErr;
    } vec_t;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic clk;
    logic reset;
    int   nAssert;
    int   nFail;
    model_t m [3];
    int   digitsOf [3] = '{2, 2, 3};
    bit   reloadOf [3] = '{1'b0, 1'b1, 1'b0};
    vec_t vecs [$];

    bcd_down_counter_if #(.DIGITS(2)) if0 ();
    bcd_down_counter_if #(.DIGITS(2)) if1 ();
    bcd_down_counter_if #(.DIGITS(3)) if2 ();

    bcd_down_counter #(.DIGITS(2), .RELOAD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    bcd_down_counter #(.DIGITS(2), .RELOAD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    bcd_down_counter #(.DIGITS(3), .RELOAD(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t modelReset();
        model_t r;
        r.value = 0; r.reloadVal = 0; r.st = ST_IDLE; r.tc = 0; r.err = 0;
        return r;
    endfunction

    // Count is held as a plain integer; BCD only appears when comparing.
    function automatic model_t modelStep(model_t cur, bit start, bit en, logic [11:0] lv,
                                         int digits, bit reloadMode);
        model_t n = cur;
        int v = 0;
        int mult = 1;
        int nib;
        n.tc = 0;
        n.err = 0;
        if (start) begin
            for (int d = 0; d < digits; d++) begin
                nib = int'((lv >> (4 * d)) & 12'hF);
                if (nib > 9) begin
                    nib = 9;
                    n.err = 1;
                end
                v += nib * mult;
                mult *= 10;
            end
            n.value = v;
            n.reloadVal = v;
            if (v != 0) begin
                n.st = ST_RUN;
            end else begin
                n.tc = 1;
                n.st = reloadMode ? ST_RUN : ST_DONE;
            end
        end else if (cur.st == ST_RUN && en) begin
            if (cur.value > 0) begin
                n.value = cur.value - 1;
                if (n.value == 0) begin
                    n.tc = 1;
                    if (!reloadMode) n.st = ST_DONE;
                end
            end else begin
                n.value = cur.reloadVal;
            end
        end
        return n;
    endfunction

    function automatic logic [11:0] toBcd(int value, int digits);
        logic [11:0] r = '0;
        int mult = 1;
        for (int d = 0; d < digits; d++) begin
            r = r | (12'((value / mult) % 10) << (4 * d));
            mult *= 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkDut(input string tag, input logic [11:0] q, input logic busy,
                            input logic done, input logic tc, input logic err,
                            input model_t mm, input int digits);
        checkOutput({tag, ".q"},        q,            toBcd(mm.value, digits));
        checkOutput({tag, ".busy"},     12'(busy),    12'(mm.st == ST_RUN));
        checkOutput({tag, ".done"},     12'(done),    12'(mm.st == ST_DONE));
        checkOutput({tag, ".tc"},       12'(tc),      12'(mm.tc));
        checkOutput({tag, ".load_err"}, 12'(err),     12'(mm.err));
    endtask

    task automatic checkModels();
        checkDut("dut0", 12'(if0.q), if0.busy, if0.done, if0.tc, if0.load_err, m[0], 2);
        checkDut("dut1", 12'(if1.q), if1.busy, if1.done, if1.tc, if1.load_err, m[1], 2);
        checkDut("dut2", if2.q,      if2.busy, if2.done, if2.tc, if2.load_err, m[2], 3);
    endtask

    task automatic applyStimulus(input bit start, input bit en, input logic [11:0] lv);
        if0.start = start; if1.start = start; if2.start = start;
        if0.en = en;       if1.en = en;       if2.en = en;
        if0.load_val = lv[7:0];
        if1.load_val = lv[7:0];
        if2.load_val = lv;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m[k] = modelStep(m[k], start, en, lv, digitsOf[k], reloadOf[k]);
        end
        #1;
        checkModels();
    endtask

    function automatic void addVec(bit start, bit en, logic [11:0] lv, logic [7:0] q,
                                   bit tc, bit busy, bit done, bit err);
        vec_t v;
        v.start = start; v.en = en; v.lv = lv; v.expQ = q;
        v.expTc = tc; v.expBusy = busy; v.expDone = done; v.expErr = err;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0]  expQ5 [8]  = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
        bit          expTc5 [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        logic [11:0] lv;
        int          sel;

        nAssert = 0;
        nFail = 0;
        reset = 1'b0;
        if0.start = 0; if1.start = 0; if2.start = 0;
        if0.en = 0;    if1.en = 0;    if2.en = 0;
        if0.load_val = '0; if1.load_val = '0; if2.load_val = '0;
        for (int k = 0; k < 3; k++) m[k] = modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.q",    12'(if0.q),                      12'h000);
        checkOutput("reset.flags", 12'({if0.busy, if0.done, if0.tc, if0.load_err}), 12'h000);
        checkModels();
        reset = 1'b1;

        // Single-shot count from 12, enable gating, saturation, restart and zero load.
        addVec(1, 0, 12'h012, 8'h12, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h11, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h10, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h09, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h08, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h07, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h06, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h05, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h04, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h03, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h02, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h01, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h00, 1, 0, 1, 0);
        addVec(0, 1, 12'h000, 8'h00, 0, 0, 1, 0);
        addVec(1, 0, 12'h020, 8'h20, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h19, 0, 1, 0, 0);
        addVec(1, 0, 12'h005, 8'h05, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h04, 0, 1, 0, 0);
        addVec(0, 0, 12'h000, 8'h04, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h03, 0, 1, 0, 0);
        addVec(1, 0, 12'h01F, 8'h19, 0, 1, 0, 1);
        addVec(0, 0, 12'h000, 8'h19, 0, 1, 0, 0);
        addVec(1, 0, 12'h007, 8'h07, 0, 1, 0, 0);
        addVec(1, 0, 12'h001, 8'h01, 0, 1, 0, 0);
        addVec(0, 1, 12'h000, 8'h00, 1, 0, 1, 0);
        addVec(1, 0, 12'h000, 8'h00, 1, 0, 1, 0);
        addVec(0, 1, 12'h000, 8'h00, 0, 0, 1, 0);
        addVec(1, 0, 12'h0AA, 8'h99, 0, 1, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].en, vecs[i].lv);
            checkOutput($sformatf("vec%0d.q", i),    12'(if0.q),        12'(vecs[i].expQ));
            checkOutput($sformatf("vec%0d.tc", i),   12'(if0.tc),       12'(vecs[i].expTc));
            checkOutput($sformatf("vec%0d.busy", i), 12'(if0.busy),     12'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d.done", i), 12'(if0.done),     12'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d.err", i),  12'(if0.load_err), 12'(vecs[i].expErr));
        end

        // Three-digit borrow across two zero digits.
        applyStimulus(1, 0, 12'h100);
        checkOutput("borrow3.load", if2.q, 12'h100);
        applyStimulus(0, 1, 12'h000);
        checkOutput("borrow3.dec", if2.q, 12'h099);

        // Auto-reload: period of four enabled cycles for a load of 3.
        applyStimulus(1, 0, 12'h003);
        checkOutput("reload.load", 12'(if1.q), 12'h003);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 12'h000);
            checkOutput($sformatf("reload%0d.q", i),    12'(if1.q),    12'(expQ5[i]));
            checkOutput($sformatf("reload%0d.tc", i),   12'(if1.tc),   12'(expTc5[i]));
            checkOutput($sformatf("reload%0d.done", i), 12'(if1.done), 12'h000);
        end

        // Asynchronous reset in the middle of a count.
        applyStimulus(1, 0, 12'h050);
        applyStimulus(0, 1, 12'h000);
        applyStimulus(0, 1, 12'h000);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) m[k] = modelReset();
        #1;
        checkOutput("asyncrst.q",    12'(if0.q), 12'h000);
        checkOutput("asyncrst.busy", 12'(if0.busy), 12'h000);
        checkModels();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 12'h000);
            checkOutput($sformatf("postrst%0d.q", i),    12'(if0.q),    12'h000);
            checkOutput($sformatf("postrst%0d.busy", i), 12'(if0.busy), 12'h000);
        end

        // Random traffic, biased towards small loads so counts reach zero.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: lv = 12'($urandom);
                1: lv = 12'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9))});
                2: lv = 12'($urandom_range(0, 9));
                default: lv = 12'({4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))});
            endcase
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
